// File: rtl/nn_inference_ctrl.sv
// nn_inference_ctrl: launches NN inference, lends it the shared RAM,
// and raises a level irq on completion or watchdog timeout.
module nn_inference_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ack,
  input  logic             irq_en,
  input  logic             nn_ready,
  output logic             run_inference,
  output logic             ram_owner_nn,
  output logic             busy,
  output logic             irq,
  output logic [7:0]       status,
  output logic [CNT_W-1:0] done_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_e;

  // Last timer value allowed in RUN; reaching it without a rise is a timeout.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] timer_q;
  logic [CNT_W-1:0] timer_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             ready_q;
  logic             rise;
  logic             done;
  logic             err;

  // Completion is the rising edge of the NN ready level.
  assign rise = nn_ready & ~ready_q;

  // State, watchdog, completion counter and ready history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      ready_q <= nn_ready;
    end
  end

  // Next-state logic; a rise beats a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        timer_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        timer_d = timer_q + CNT_W'(1);
        if (rise) begin
          state_d = S_DONE;
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (timer_q == TMO_LAST) begin
          state_d = S_ERR;
        end
      end
      S_DONE: begin
        if (ack) state_d = S_IDLE;
      end
      S_ERR: begin
        if (ack) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs; irq is gated live by irq_en so polling mode works.
  always_comb begin
    run_inference = 1'b0;
    ram_owner_nn  = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    unique case (state_q)
      S_LAUNCH: begin
        run_inference = 1'b1;
        ram_owner_nn  = 1'b1;
        busy          = 1'b1;
      end
      S_RUN: begin
        ram_owner_nn = 1'b1;
        busy         = 1'b1;
      end
      S_DONE:  done = 1'b1;
      S_ERR:   err  = 1'b1;
      default: begin
        run_inference = 1'b0;
      end
    endcase
    irq    = (done | err) & irq_en;
    status = {4'b0000, err, done, busy, ram_owner_nn};
  end

  assign done_count = cnt_q;

endmodule

// File: tb/tb_nn_inference_ctrl.sv
// tb_nn_inference_ctrl: directed stimulus, per-cycle expected outputs
// queued by the driver and compared by a negedge monitor.
module tb_nn_inference_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ack;
  logic        irq_en;
  logic        nn_ready;

  logic        run_inference;
  logic        ram_owner_nn;
  logic        busy;
  logic        irq;
  logic [7:0]  status;
  logic [15:0] done_count;

  logic        run_inference4;
  logic        ram_owner_nn4;
  logic        busy4;
  logic        irq4;
  logic [7:0]  status4;
  logic [3:0]  done_count4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  st;
    logic        irq;
    logic        ri;
    logic [15:0] cnt;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  nn_inference_ctrl #(
    .TIMEOUT_CYCLES(16),
    .CNT_W(16)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .ack(ack),
    .irq_en(irq_en),
    .nn_ready(nn_ready),
    .run_inference(run_inference),
    .ram_owner_nn(ram_owner_nn),
    .busy(busy),
    .irq(irq),
    .status(status),
    .done_count(done_count)
  );

  // Narrow-counter copy so counter wrap is reachable in a short run.
  nn_inference_ctrl #(
    .TIMEOUT_CYCLES(16),
    .CNT_W(4)
  ) u_dut4 (
    .clk(clk),
    .reset(reset),
    .start(start),
    .ack(ack),
    .irq_en(irq_en),
    .nn_ready(nn_ready),
    .run_inference(run_inference4),
    .ram_owner_nn(ram_owner_nn4),
    .busy(busy4),
    .irq(irq4),
    .status(status4),
    .done_count(done_count4)
  );

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h",
               nm, $time, act, exp);
    end
  endtask

  // Drive inputs for one cycle and queue the outputs expected in it.
  task automatic step(input logic r, s, a, e, n,
                      input logic [7:0] xs,
                      input logic xi, xr,
                      input logic [15:0] xc);
    exp_t x;
    @(posedge clk);
    #1;
    reset    = r;
    start    = s;
    ack      = a;
    irq_en   = e;
    nn_ready = n;
    x.st  = xs;
    x.irq = xi;
    x.ri  = xr;
    x.cnt = xc;
    sbq.push_back(x);
  endtask

  task automatic short_run(input int k);
    step(0, 1, 0, 1, 0, 8'h00, 0, 0, 16'(k));
    step(0, 0, 0, 1, 0, 8'h03, 0, 1, 16'(k));
    step(0, 0, 0, 1, 1, 8'h03, 0, 0, 16'(k));
    step(0, 0, 1, 1, 0, 8'h04, 1, 0, 16'(k + 1));
  endtask

  // Monitor: compare every output against the queued expectation.
  always @(negedge clk) begin
    exp_t x;
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      chk("status", 16'(status), 16'(x.st));
      chk("irq", 16'(irq), 16'(x.irq));
      chk("run_inference", 16'(run_inference), 16'(x.ri));
      chk("busy", 16'(busy), 16'(x.st[1]));
      chk("ram_owner_nn", 16'(ram_owner_nn), 16'(x.st[0]));
      chk("done_count", done_count, x.cnt);
      chk("done_count4", 16'(done_count4), {12'h000, x.cnt[3:0]});
    end
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    ack      = 1'b0;
    irq_en   = 1'b1;
    nn_ready = 1'b0;

    // reset
    step(1, 0, 0, 1, 0, 8'h00, 0, 0, 0);
    step(1, 0, 0, 1, 0, 8'h00, 0, 0, 0);

    // basic run, rise in RUN cycle 5, ack 3 cycles later
    step(0, 1, 0, 1, 0, 8'h00, 0, 0, 0);
    step(0, 0, 0, 1, 0, 8'h03, 0, 1, 0);
    repeat (4) step(0, 0, 0, 1, 0, 8'h03, 0, 0, 0);
    step(0, 0, 0, 1, 1, 8'h03, 0, 0, 0);
    step(0, 0, 0, 1, 1, 8'h04, 1, 0, 1);
    step(0, 0, 0, 1, 1, 8'h04, 1, 0, 1);
    step(0, 0, 1, 1, 1, 8'h04, 1, 0, 1);
    step(0, 0, 0, 1, 0, 8'h00, 0, 0, 1);

    // watchdog: 16 RUN cycles then ERR, start ignored in ERR
    step(0, 1, 0, 1, 0, 8'h00, 0, 0, 1);
    step(0, 0, 0, 1, 0, 8'h03, 0, 1, 1);
    repeat (16) step(0, 0, 0, 1, 0, 8'h03, 0, 0, 1);
    step(0, 1, 0, 1, 0, 8'h08, 1, 0, 1);
    step(0, 0, 1, 1, 0, 8'h08, 1, 0, 1);
    step(0, 0, 0, 1, 0, 8'h00, 0, 0, 1);

    // polling mode, then irq_en raised while in DONE
    step(0, 1, 0, 0, 0, 8'h00, 0, 0, 1);
    step(0, 0, 0, 0, 0, 8'h03, 0, 1, 1);
    step(0, 0, 0, 0, 0, 8'h03, 0, 0, 1);
    step(0, 0, 0, 0, 1, 8'h03, 0, 0, 1);
    step(0, 0, 0, 0, 1, 8'h04, 0, 0, 2);
    step(0, 0, 0, 1, 0, 8'h04, 1, 0, 2);
    step(0, 0, 1, 1, 0, 8'h04, 1, 0, 2);
    step(0, 0, 0, 1, 0, 8'h00, 0, 0, 2);

    // start held through RUN and DONE: one launch pulse
    step(0, 1, 0, 1, 0, 8'h00, 0, 0, 2);
    step(0, 1, 0, 1, 0, 8'h03, 0, 1, 2);
    step(0, 1, 0, 1, 0, 8'h03, 0, 0, 2);
    step(0, 1, 0, 1, 1, 8'h03, 0, 0, 2);
    step(0, 1, 0, 1, 1, 8'h04, 1, 0, 3);
    step(0, 0, 1, 1, 1, 8'h04, 1, 0, 3);
    step(0, 0, 0, 1, 0, 8'h00, 0, 0, 3);

    // nn_ready rising while IDLE does nothing
    step(0, 0, 0, 1, 1, 8'h00, 0, 0, 3);
    step(0, 0, 0, 1, 1, 8'h00, 0, 0, 3);

    // nn_ready high from before start: no rise, timeout
    step(0, 1, 0, 1, 1, 8'h00, 0, 0, 3);
    step(0, 0, 0, 1, 1, 8'h03, 0, 1, 3);
    repeat (16) step(0, 0, 0, 1, 1, 8'h03, 0, 0, 3);
    step(0, 0, 1, 1, 0, 8'h08, 1, 0, 3);
    step(0, 0, 0, 1, 0, 8'h00, 0, 0, 3);

    // rise at timer=15 coincides with timeout: DONE wins
    step(0, 1, 0, 1, 0, 8'h00, 0, 0, 3);
    step(0, 0, 0, 1, 0, 8'h03, 0, 1, 3);
    repeat (15) step(0, 0, 0, 1, 0, 8'h03, 0, 0, 3);
    step(0, 0, 0, 1, 1, 8'h03, 0, 0, 3);
    step(0, 0, 1, 1, 0, 8'h04, 1, 0, 4);
    step(0, 0, 0, 1, 0, 8'h00, 0, 0, 4);

    // reset in RUN cycle 3
    step(0, 1, 0, 1, 0, 8'h00, 0, 0, 4);
    step(0, 0, 0, 1, 0, 8'h03, 0, 1, 4);
    step(0, 0, 0, 1, 0, 8'h03, 0, 0, 4);
    step(0, 0, 0, 1, 0, 8'h03, 0, 0, 4);
    step(1, 0, 0, 1, 0, 8'h03, 0, 0, 4);
    step(0, 0, 0, 1, 0, 8'h00, 0, 0, 0);

    // 16 short runs: 4-bit counter wraps to 0
    for (int k = 0; k < 16; k++) short_run(k);
    step(0, 0, 0, 1, 0, 8'h00, 0, 0, 16);

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
